// File: rtl/cpu_scoreboard.sv
// Decode-stage scoreboard for long-latency destination registers.
// Holds a saturating 2-bit in-flight count per architectural register plus a global total.
module cpu_scoreboard #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_flush,
  input  logic       i_issue_valid,
  input  logic       i_issue_long,
  input  logic [4:0] i_issue_rd,
  output logic       o_issue_ready,
  input  logic       i_retire_valid,
  input  logic [4:0] i_retire_rd,
  input  logic [1:0] i_have_rs,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  output logic       o_stall,
  output logic [3:0] o_outstanding,
  output logic       o_underflow
);

  localparam logic [3:0] MAX_Q = 4'(MAX_OUTSTANDING);

  logic [1:0] pend [32];
  logic [3:0] total_q, total_d;
  logic       underflow_q, underflow_d;

  logic [1:0] issue_pend, retire_pend, rs1_pend, rs2_pend;
  logic       retire_hit, retire_ok, underflow_hit;
  logic       rs1_busy, rs2_busy;
  logic       fire;

  assign pend[0] = 2'd0;

  always_comb begin
    issue_pend    = pend[i_issue_rd];
    retire_pend   = pend[i_retire_rd];
    rs1_pend      = pend[i_rs1];
    rs2_pend      = pend[i_rs2];

    retire_hit    = i_retire_valid & (i_retire_rd != 5'd0);
    retire_ok     = retire_hit & (retire_pend != 2'd0) & ~i_flush;
    underflow_hit = retire_hit & (retire_pend == 2'd0) & ~i_flush;

    // A final retire of the source this cycle is forwardable, so it does not stall.
    rs1_busy = i_have_rs[0] & (i_rs1 != 5'd0) & (rs1_pend != 2'd0) &
               ~(retire_hit & (i_retire_rd == i_rs1) & (rs1_pend == 2'd1));
    rs2_busy = i_have_rs[1] & (i_rs2 != 5'd0) & (rs2_pend != 2'd0) &
               ~(retire_hit & (i_retire_rd == i_rs2) & (rs2_pend == 2'd1));

    o_stall       = ~i_flush & (rs1_busy | rs2_busy);
    o_issue_ready = (i_issue_rd == 5'd0) | ((total_q < MAX_Q) & (issue_pend != 2'd3));

    fire = i_issue_valid & i_issue_long & o_issue_ready & ~o_stall &
           (i_issue_rd != 5'd0) & ~i_flush;

    total_d = total_q;
    if (i_flush) begin
      total_d = 4'd0;
    end else if (fire & ~retire_ok) begin
      total_d = total_q + 4'd1;
    end else if (retire_ok & ~fire) begin
      total_d = total_q - 4'd1;
    end

    underflow_d = underflow_q | underflow_hit;
  end

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_pend
      logic [1:0] cnt_q, cnt_d;
      logic       inc, dec;

      always_comb begin
        inc   = fire & (i_issue_rd == 5'(gi));
        dec   = retire_ok & (i_retire_rd == 5'(gi));
        cnt_d = cnt_q;
        if (i_flush) begin
          cnt_d = 2'd0;
        end else if (inc & ~dec) begin
          cnt_d = cnt_q + 2'd1;
        end else if (dec & ~inc) begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          cnt_q <= 2'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign pend[gi] = cnt_q;
    end
  endgenerate

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      total_q     <= 4'd0;
      underflow_q <= 1'b0;
    end else begin
      total_q     <= total_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_outstanding = total_q;
  assign o_underflow   = underflow_q;

endmodule
